rr_arb8: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 8:1-muxed resource among 8 requesters.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick8.sv | 30 +++
 rtl/rr_arb8.sv | 120 ++++++++++++
 tb/tb_rr_arb8.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
//   arb_state_e : arbiter FSM state encoding
//   ARB_N       : number of requesters
//   ARB_SEL_W   : width of the mux select / requester index
//   onehot8()   : index -> one-hot requester vector
package arb_pkg;

    localparam int unsigned ARB_N     = 8;
    localparam int unsigned ARB_SEL_W = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StGrant = 2'b01,
        StTurn  = 2'b10
    } arb_state_e;

    function automatic logic [ARB_N-1:0] onehot8(input logic [ARB_SEL_W-1:0] idx);
        logic [ARB_N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-priority encoder.
//   req [7:0] in  : request vector
//   ptr [2:0] in  : index with highest priority
//   any       out : at least one request present
//   idx [2:0] out : first requesting index scanning ptr, ptr+1, ... modulo 8
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_SEL_W-1:0] ptr,
    output logic                 any,
    output logic [ARB_SEL_W-1:0] idx
);

    logic [ARB_SEL_W-1:0] cand;

    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        // Scan from the farthest slot back to ptr so the nearest hit wins.
        for (int k = ARB_N - 1; k >= 0; k--) begin
            cand = ptr + ARB_SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter sharing one 8:1-muxed resource among 8 requesters.
//   clk      in  : system clock, rising edge
//   rst_n    in  : asynchronous reset, active-low
//   req[7:0] in  : level requests, held until served
//   rel      in  : release pulse from the current owner (only honoured in grant)
//   gnt[7:0] out : registered one-hot grant, zero when nobody owns the resource
//   sel[2:0] out : registered mux select, index of current/last owner
//   valid    out : high while a grant is active
//   preempt  out : one-cycle pulse when a grant was ended by hold timeout
// A grant ends on release, request drop, or hold budget expiry while others wait.
// Every grant end is followed by one turnaround cycle before re-arbitration.
module rr_arb8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ARB_N-1:0]     req,
    input  logic                 rel,
    output logic [ARB_N-1:0]     gnt,
    output logic [ARB_SEL_W-1:0] sel,
    output logic                 valid,
    output logic                 preempt
);

    localparam int unsigned      HoldW     = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] MaxHold   = HoldW'(MAX_HOLD);
    localparam bit               TimeoutEn = (MAX_HOLD != 0);

    arb_state_e           state_q, state_d;
    logic [ARB_SEL_W-1:0] ptr_q, ptr_d;
    logic [ARB_SEL_W-1:0] sel_q, sel_d;
    logic [ARB_N-1:0]     gnt_q, gnt_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic                 preempt_q, preempt_d;

    logic                 pick_any;
    logic [ARB_SEL_W-1:0] pick_idx;
    logic                 own_req;
    logic                 others;
    logic                 timeout;
    logic                 grant_end;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign own_req   = req[sel_q];
    assign others    = |(req & ~onehot8(sel_q));
    // A lone owner past its budget keeps the grant: timeout needs a competitor.
    assign timeout   = TimeoutEn && (hold_q >= MaxHold) && others;
    assign grant_end = rel | ~own_req | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d   = onehot8(pick_idx);
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx + ARB_SEL_W'(1);  // wraps modulo 8
                    hold_d  = HoldW'(1);
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (grant_end) begin
                    gnt_d     = '0;
                    state_d   = StTurn;
                    // Only flag a pure timeout; a coincident release wins.
                    preempt_d = ~rel & own_req;
                end else if (hold_q < MaxHold) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        gnt     = gnt_q;
        sel     = sel_q;
        valid   = (state_q == StGrant);
        preempt = preempt_q;
    end

endmodule

// File: tb/tb_rr_arb8.sv
module tb_rr_arb8;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    rr_arb8 #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .sel     (sel),
        .valid   (valid),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), turnaround flag, priority pointer.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_turn  = 1'b0;
    bit m_pre   = 1'b0;

    function automatic int pick_model(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_last  <= 0;
            m_ptr   <= 0;
            m_hold  <= 0;
            m_turn  <= 1'b0;
            m_pre   <= 1'b0;
        end else if (m_owner >= 0) begin
            if (rel || !req[m_owner] ||
                (MAXH != 0 && m_hold >= MAXH && (req & ~(8'h01 << m_owner)) != 8'h00)) begin
                m_owner <= -1;
                m_turn  <= 1'b1;
                m_pre   <= !(rel || !req[m_owner]);
            end else begin
                m_hold <= (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
            end
        end else if (m_turn) begin
            m_turn <= 1'b0;
            m_pre  <= 1'b0;
        end else begin
            m_pre <= 1'b0;
            if (req != 8'h00) begin
                m_owner <= pick_model(req, m_ptr);
                m_last  <= pick_model(req, m_ptr);
                m_ptr   <= (pick_model(req, m_ptr) + 1) % 8;
                m_hold  <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_gnt", {24'h0, gnt},
                  (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
            check("model_sel", {29'h0, sel}, m_last);
            check("model_valid", {31'h0, valid}, (m_owner >= 0) ? 1 : 0);
            check("model_preempt", {31'h0, preempt}, {31'h0, m_pre});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit [7:0] seen;
        bit       pre_seen;
        bit       gnt_bad;
        int       waitc;

        // Reset state
        step(2);
        check("rst_gnt", {24'h0, gnt}, 32'h00);
        check("rst_sel", {29'h0, sel}, 32'd0);
        check("rst_valid", {31'h0, valid}, 32'd0);
        check("rst_preempt", {31'h0, preempt}, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // 1: async reset mid-grant
        req = 8'h08;
        step(1);
        check("t1_gnt3", {24'h0, gnt}, 32'h08);
        check("t1_sel3", {29'h0, sel}, 32'd3);
        step(1);
        rst_n = 1'b0;
        #1;
        check("t1_async_gnt", {24'h0, gnt}, 32'h00);
        check("t1_async_sel", {29'h0, sel}, 32'd0);
        check("t1_async_valid", {31'h0, valid}, 32'd0);
        req = 8'h30;
        #2;
        rst_n = 1'b1;
        step(1);
        check("t1_first_gnt", {24'h0, gnt}, 32'h10);
        check("t1_first_sel", {29'h0, sel}, 32'd4);
        rel = 1'b1; req = 8'h00;
        step(1);
        rel = 1'b0;
        step(3);

        // 2: single request, release, regrant after turnaround
        req = 8'h20;
        step(1);
        check("t2_gnt", {24'h0, gnt}, 32'h20);
        check("t2_sel", {29'h0, sel}, 32'd5);
        check("t2_valid", {31'h0, valid}, 32'd1);
        rel = 1'b1;
        step(1);
        rel = 1'b0;
        check("t2_turn_gnt", {24'h0, gnt}, 32'h00);
        check("t2_turn_valid", {31'h0, valid}, 32'd0);
        step(1);
        check("t2_idle_gnt", {24'h0, gnt}, 32'h00);
        step(1);
        check("t2_regrant", {24'h0, gnt}, 32'h20);
        rel = 1'b1; req = 8'h00;
        step(1);
        rel = 1'b0;
        step(2);

        // Bring ptr to 0 via a grant of index 7
        req = 8'h80;
        step(1);
        check("t3_pre_gnt7", {24'h0, gnt}, 32'h80);
        rel = 1'b1; req = 8'h00;
        step(1);
        rel = 1'b0;
        step(2);

        // 3: rotation with all requesting
        req  = 8'hFF;
        seen = 8'h00;
        for (int g = 0; g < 9; g++) begin
            waitc = 0;
            while (!valid && waitc < 6) begin
                step(1);
                waitc++;
            end
            check("t3_valid", {31'h0, valid}, 32'd1);
            check("t3_order", {29'h0, sel}, g % 8);
            if (g < 8) seen[sel] = 1'b1;
            rel = 1'b1;
            step(1);
            rel = 1'b0;
        end
        check("t3_all_seen", {24'h0, seen}, 32'hFF);
        req = 8'h00;
        step(3);

        // 4: preempt on timeout (ptr = 1 here)
        req = 8'h04;
        step(1);
        req = 8'h44;
        check("t4_hold1", {24'h0, gnt}, 32'h04);
        step(3);
        check("t4_hold4", {24'h0, gnt}, 32'h04);
        check("t4_hold4_pre", {31'h0, preempt}, 32'd0);
        step(1);
        check("t4_end_gnt", {24'h0, gnt}, 32'h00);
        check("t4_preempt", {31'h0, preempt}, 32'd1);
        step(1);
        check("t4_pre_clear", {31'h0, preempt}, 32'd0);
        step(1);
        check("t4_next_gnt", {24'h0, gnt}, 32'h40);
        check("t4_next_sel", {29'h0, sel}, 32'd6);
        rel = 1'b1; req = 8'h00;
        step(1);
        rel = 1'b0;
        step(2);

        // 5: lone owner never preempted
        req = 8'h04;
        step(1);
        pre_seen = 1'b0;
        gnt_bad  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (gnt !== 8'h04) gnt_bad = 1'b1;
            if (preempt) pre_seen = 1'b1;
            step(1);
        end
        check("t5_gnt_held", {31'h0, gnt_bad}, 32'd0);
        check("t5_no_preempt", {31'h0, pre_seen}, 32'd0);
        req = 8'h00;
        step(3);

        // 6a: owner drops request
        req = 8'h02;
        step(1);
        check("t6_gnt1", {24'h0, gnt}, 32'h02);
        req = 8'h00;
        step(1);
        check("t6_drop_gnt", {24'h0, gnt}, 32'h00);
        step(2);

        // 6b: release coincident with timeout (ptr = 2)
        req = 8'h0C;
        step(1);
        check("t6_gnt2", {24'h0, gnt}, 32'h04);
        step(3);
        rel = 1'b1;
        step(1);
        rel = 1'b0;
        req = 8'h00;
        check("t6_coll_gnt", {24'h0, gnt}, 32'h00);
        check("t6_coll_pre", {31'h0, preempt}, 32'd0);
        step(3);

        // 6c: rel in IDLE is ignored
        rel = 1'b1;
        step(1);
        rel = 1'b0;
        check("t6_idle_gnt", {24'h0, gnt}, 32'h00);
        check("t6_idle_valid", {31'h0, valid}, 32'd0);
        check("t6_idle_sel", {29'h0, sel}, 32'd2);
        step(2);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
